inverter_n: RTL and testbench

//  Modular inverse mod the curve group order: inverse = a^-1 mod params.n (binary extended Euclid).

---
 rtl/inverter_n_pkg.sv | 33 +++
 rtl/inverter_n_chk.sv | 29 ++
 rtl/inverter_n_halve_mod_n.sv | 33 +++
 rtl/inverter_n_reg_256.sv | 32 +++
 rtl/inverter_n.sv | 186 ++++++++++++++++++
 tb/tb_inverter_n.sv | 185 ++++++++++++++++++
 6 files changed

// File: rtl/inverter_n_pkg.sv
// ---------------------------------------------------------------------------
// elliptic_curve_structs
// Shared types for the ECDSA signing datapath.
//   curve_parameters_t : domain parameters of the active curve
//   inv_state_t        : state encoding of the modular inverter (inverter_n)
//   INV_MAX_CYCLES     : worst-case Start->Done latency of inverter_n
// ---------------------------------------------------------------------------
package elliptic_curve_structs;

  localparam int CURVE_WIDTH = 256;

  typedef struct packed {
    logic [CURVE_WIDTH-1:0] p;   // field prime
    logic [CURVE_WIDTH-1:0] a;   // curve coefficient a
    logic [CURVE_WIDTH-1:0] b;   // curve coefficient b
    logic [CURVE_WIDTH-1:0] gx;  // base point x
    logic [CURVE_WIDTH-1:0] gy;  // base point y
    logic [CURVE_WIDTH-1:0] n;   // group order (odd, > 2)
  } curve_parameters_t;

  typedef enum logic [2:0] {
    INV_IDLE   = 3'd0,
    INV_REDUCE = 3'd1,
    INV_RUN    = 3'd2,
    INV_DONE   = 3'd3,
    INV_ERR    = 3'd4
  } inv_state_t;

  // Each RUN step removes at least one bit from u*v every two cycles,
  // plus a few cycles of handshake overhead.
  localparam int INV_MAX_CYCLES = 4 * CURVE_WIDTH + 6;

endpackage

// File: rtl/inverter_n_chk.sv
// ---------------------------------------------------------------------------
// inverter_n_chk
// Protocol properties of the inverter's status outputs.
// Ports:
//   clk, Reset_n         in  clock / async active-low reset
//   Busy, Done, Error    in  status outputs of inverter_n
//   inverse              in  result output of inverter_n
// ---------------------------------------------------------------------------
module inverter_n_chk #(
  parameter int WIDTH = 256
) (
  input logic             clk,
  input logic             Reset_n,
  input logic             Busy,
  input logic             Done,
  input logic             Error,
  input logic [WIDTH-1:0] inverse
);

  a_done_error_excl: assert property (@(posedge clk) disable iff (!Reset_n)
    !(Done && Error));

  a_busy_no_status: assert property (@(posedge clk) disable iff (!Reset_n)
    Busy |-> (!Done && !Error));

  a_busy_inverse_zero: assert property (@(posedge clk) disable iff (!Reset_n)
    Busy |-> (inverse == {WIDTH{1'b0}}));

endmodule

// File: rtl/inverter_n_halve_mod_n.sv
// ---------------------------------------------------------------------------
// halve_mod_n
// Combinational division by two modulo an odd n:
//   y = x even ? x/2 : (x+n)/2
// x must lie in [0,n). The sum is formed one bit wider than x so the carry
// out of x+n is kept before the shift.
// Ports:
//   x   in   WIDTH+1  value to halve, in [0,n)
//   n   in   WIDTH    odd modulus
//   y   out  WIDTH+1  x * 2^-1 mod n, in [0,n)
// ---------------------------------------------------------------------------
module halve_mod_n #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH:0]   y
);

  logic [WIDTH+1:0] sum_s;

  // Make x even by adding the odd modulus when needed, then shift
  always_comb begin
    sum_s = {1'b0, x};
    if (x[0]) begin
      sum_s = {1'b0, x} + {2'b00, n};
    end else begin
      sum_s = {1'b0, x};
    end
    y = sum_s[WIDTH+1:1];
  end

endmodule

// File: rtl/inverter_n_reg_256.sv
// ---------------------------------------------------------------------------
// reg_256
// Parameterised enabled register with asynchronous active-low reset to zero.
// Ports:
//   clk      in   clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   en       in   load enable
//   d        in   next value
//   q        out  registered value
// ---------------------------------------------------------------------------
module reg_256 #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage with async clear
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/inverter_n.sv
// ---------------------------------------------------------------------------
// inverter_n
// Modular inverse modulo the curve group order, inverse = a^-1 mod params.n,
// by the binary extended Euclidean algorithm, one reduction step per clock.
// Invariants while running: x1*a == u and x2*a == v (mod n_r).
// Ports:
//   clk      in   clock, all state on rising edge
//   Reset_n  in   asynchronous active-low reset
//   Start    in   1-cycle pulse; samples a and params.n (ignored while Busy)
//   a        in   operand, any value (reduced mod n internally)
//   params   in   curve parameters; only .n is used (odd, > 2)
//   Busy     out  high while computing
//   Done     out  level, inverse valid; cleared by next Start
//   Error    out  level, no inverse exists; cleared by next Start
//   inverse  out  a^-1 mod n when Done, 0 otherwise
// ---------------------------------------------------------------------------
module inverter_n
  import elliptic_curve_structs::*;
#(
  parameter int WIDTH = CURVE_WIDTH
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [WIDTH-1:0]  a,
  input  curve_parameters_t params,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [WIDTH-1:0]  inverse
);

  localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};

  inv_state_t       state_r, state_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             error_r, error_s;
  logic [WIDTH:0]   u_r, u_s;
  logic [WIDTH:0]   v_r, v_s;
  logic [WIDTH:0]   x1_r, x1_s;
  logic [WIDTH:0]   x2_r, x2_s;
  logic [WIDTH-1:0] n_r, n_s;
  logic [WIDTH-1:0] inverse_r, inverse_s;
  logic [WIDTH:0]   x1_half_s, x2_half_s;
  logic [WIDTH-1:0] n_in_s;
  logic             params_unused_s;

  assign n_in_s          = params.n[WIDTH-1:0];
  assign params_unused_s = ^{params.p, params.a, params.b, params.gx, params.gy};

  // Subtraction modulo m for operands already in [0,m)
  function automatic logic [WIDTH:0] mod_sub(input logic [WIDTH:0]   x,
                                             input logic [WIDTH:0]   y,
                                             input logic [WIDTH-1:0] m);
    logic [WIDTH:0] diff;
    diff = x - y;
    if (x >= y) begin
      return diff;
    end else begin
      return diff + {1'b0, m};
    end
  endfunction

  halve_mod_n #(.WIDTH(WIDTH)) u_halve_x1 (.x(x1_r), .n(n_r), .y(x1_half_s));
  halve_mod_n #(.WIDTH(WIDTH)) u_halve_x2 (.x(x2_r), .n(n_r), .y(x2_half_s));

  reg_256 #(.WIDTH(WIDTH+1)) u_reg_u   (.clk(clk), .Reset_n(Reset_n), .en(1'b1), .d(u_s),       .q(u_r));
  reg_256 #(.WIDTH(WIDTH+1)) u_reg_v   (.clk(clk), .Reset_n(Reset_n), .en(1'b1), .d(v_s),       .q(v_r));
  reg_256 #(.WIDTH(WIDTH+1)) u_reg_x1  (.clk(clk), .Reset_n(Reset_n), .en(1'b1), .d(x1_s),      .q(x1_r));
  reg_256 #(.WIDTH(WIDTH+1)) u_reg_x2  (.clk(clk), .Reset_n(Reset_n), .en(1'b1), .d(x2_s),      .q(x2_r));
  reg_256 #(.WIDTH(WIDTH))   u_reg_n   (.clk(clk), .Reset_n(Reset_n), .en(1'b1), .d(n_s),       .q(n_r));
  reg_256 #(.WIDTH(WIDTH))   u_reg_inv (.clk(clk), .Reset_n(Reset_n), .en(1'b1), .d(inverse_s), .q(inverse_r));

  // Next-state, datapath step and next outputs
  always_comb begin
    state_s   = state_r;
    busy_s    = busy_r;
    done_s    = done_r;
    error_s   = error_r;
    u_s       = u_r;
    v_s       = v_r;
    x1_s      = x1_r;
    x2_s      = x2_r;
    n_s       = n_r;
    inverse_s = inverse_r;
    case (state_r)
      INV_IDLE, INV_DONE, INV_ERR: begin
        if (Start) begin
          state_s   = INV_REDUCE;
          busy_s    = 1'b1;
          done_s    = 1'b0;
          error_s   = 1'b0;
          u_s       = {1'b0, a};
          v_s       = {1'b0, n_in_s};
          x1_s      = ONE_W;
          x2_s      = ZERO_W;
          n_s       = n_in_s;
          inverse_s = {WIDTH{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      INV_REDUCE: begin
        // Bring a into [0,n) by repeated subtraction
        if (u_r >= {1'b0, n_r}) begin
          u_s = u_r - {1'b0, n_r};
        end else if (u_r == ZERO_W) begin
          state_s = INV_ERR;
          busy_s  = 1'b0;
          error_s = 1'b1;
        end else begin
          state_s = INV_RUN;
        end
      end
      INV_RUN: begin
        if (u_r == ONE_W) begin
          state_s   = INV_DONE;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          inverse_s = x1_r[WIDTH-1:0];
        end else if (v_r == ONE_W) begin
          state_s   = INV_DONE;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          inverse_s = x2_r[WIDTH-1:0];
        end else if ((u_r == ZERO_W) || (v_r == ZERO_W)) begin
          // gcd(a,n) > 1: no inverse exists, stop instead of spinning
          state_s = INV_ERR;
          busy_s  = 1'b0;
          error_s = 1'b1;
        end else if (!u_r[0]) begin
          u_s  = {1'b0, u_r[WIDTH:1]};
          x1_s = x1_half_s;
        end else if (!v_r[0]) begin
          v_s  = {1'b0, v_r[WIDTH:1]};
          x2_s = x2_half_s;
        end else if (u_r >= v_r) begin
          u_s  = u_r - v_r;
          x1_s = mod_sub(x1_r, x2_r, n_r);
        end else begin
          v_s  = v_r - u_r;
          x2_s = mod_sub(x2_r, x1_r, n_r);
        end
      end
      default: begin
        state_s   = INV_IDLE;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        error_s   = 1'b0;
        inverse_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= INV_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign Error   = error_r;
  assign inverse = inverse_r;

  inverter_n_chk #(.WIDTH(WIDTH)) u_chk (
    .clk     (clk),
    .Reset_n (Reset_n),
    .Busy    (busy_r),
    .Done    (done_r),
    .Error   (error_r),
    .inverse (inverse_r)
  );

endmodule

// File: tb/tb_inverter_n.sv
// ---------------------------------------------------------------------------
// tb_inverter_n
// Directed and random vectors for inverter_n. Expected results come from a
// Fermat-exponentiation model (n prime), pinned by hand-computed literals.
// ---------------------------------------------------------------------------
module tb_inverter_n;
  import elliptic_curve_structs::*;

  localparam int W = 256;
  localparam logic [W-1:0] N97   = 256'd97;
  localparam logic [W-1:0] NSECP = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [W-1:0] INV2_SECP = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF5D576E7357A4501DDFE92F46681B20A1;

  logic              clk = 1'b0;
  logic              Reset_n;
  logic              Start;
  logic [W-1:0]      a;
  curve_parameters_t params;
  logic              Busy, Done, Error;
  logic [W-1:0]      inverse;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        exp_armed = 1'b0;
  logic        exp_err = 1'b0;
  logic [W-1:0] exp_inv = '0;

  inverter_n #(.WIDTH(W)) dut (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .a(a), .params(params),
    .Busy(Busy), .Done(Done), .Error(Error), .inverse(inverse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] r, x, mm;
    mm = {{W{1'b0}}, m};
    r  = 1;
    x  = {{W{1'b0}}, b} % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[W-1:0];
  endfunction

  // Inverse by Fermat's little theorem: a^(n-2) mod n; error when a == 0 mod n
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] nv,
                       output logic e, output logic [W-1:0] inv);
    logic [W-1:0] r;
    r = av % nv;
    if (r == '0) begin
      e = 1'b1; inv = '0;
    end else begin
      e = 1'b0; inv = modpow(r, nv - 256'd2, nv);
    end
  endtask

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (Reset_n === 1'b1) begin
      chk("done_error_exclusive", W'(Done & Error), 256'd0);
      if (Busy) begin
        chk("status_while_busy", W'({Done, Error}), 256'd0);
        chk("inverse_while_busy", inverse, 256'd0);
      end
      if (exp_armed && (Done || Error)) begin
        chk("done_level", W'(Done), W'(!exp_err));
        chk("error_level", W'(Error), W'(exp_err));
        chk("inverse_value", inverse, exp_inv);
      end
    end
  end

  task automatic run_vec(input logic [W-1:0] av, input logic [W-1:0] nv, input bit disturb);
    logic         e;
    logic [W-1:0] inv;
    int           cyc;
    model(av, nv, e, inv);
    @(negedge clk);
    a = av; params.n = nv; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    exp_err = e; exp_inv = inv; exp_armed = 1'b1;
    chk("busy_after_start", W'(Busy), 256'd1);
    chk("status_cleared_by_start", W'({Done, Error}), 256'd0);
    cyc = 1;
    while (!(Done || Error) && cyc <= INV_MAX_CYCLES + 8) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 4) begin
        Start = 1'b1; a = av ^ 256'h5; params.n = N97;
      end else if (disturb && cyc == 5) begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    chk("completed", W'(Done || Error), 256'd1);
    chk("latency_within_bound", W'(cyc <= INV_MAX_CYCLES), 256'd1);
    chk("busy_cleared", W'(Busy), 256'd0);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_below_n();
    logic [W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    if (r >= NSECP) r = r - NSECP;
    if (r == '0) r = 256'd1;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic         me;
    logic [W-1:0] mi;
    Reset_n = 1'b0; Start = 1'b0; a = '0; params = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", W'(Busy), 256'd0);
    chk("reset_done", W'(Done), 256'd0);
    chk("reset_error", W'(Error), 256'd0);
    chk("reset_inverse", inverse, 256'd0);
    @(negedge clk);
    Reset_n = 1'b1;

    // Pin the model with hand-computed results
    model(256'd3, N97, me, mi);   chk("model_inv3_mod97", mi, 256'd65);
    model(256'd96, N97, me, mi);  chk("model_inv96_mod97", mi, 256'd96);
    model(256'd100, N97, me, mi); chk("model_inv100_mod97", mi, 256'd65);
    model(256'd194, N97, me, mi); chk("model_err194_mod97", W'(me), 256'd1);
    model(256'd2, NSECP, me, mi); chk("model_inv2_secp", mi, INV2_SECP);

    run_vec(256'd3, N97, 1'b0);
    run_vec(256'd1, N97, 1'b0);
    run_vec(256'd96, N97, 1'b0);
    run_vec(256'd100, N97, 1'b0);
    run_vec(256'd0, N97, 1'b0);
    run_vec(256'd194, N97, 1'b0);
    run_vec(256'd3, N97, 1'b0);
    run_vec(256'd2, NSECP, 1'b0);

    // Reset in the middle of a long run
    @(negedge clk);
    a = rand_below_n(); params.n = NSECP; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; exp_armed = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midreset_busy", W'(Busy), 256'd0);
    chk("midreset_done", W'(Done), 256'd0);
    chk("midreset_error", W'(Error), 256'd0);
    chk("midreset_inverse", inverse, 256'd0);
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    chk("no_stale_status", W'({Busy, Done, Error}), 256'd0);
    run_vec(256'd3, N97, 1'b0);

    // Random operands; the first two get a Start pulse and an n change mid-run
    for (int i = 0; i < 40; i++) begin
      run_vec(rand_below_n(), NSECP, (i < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
